quad_input_conditioner: RTL and testbench
=========================================

// Module: quad_input_conditioner
// PURPOSE
//   Conditions one raw rotary-encoder channel pair (A/B) from the ui_in pins before it reaches
//   the paddle position logic. Two-flop synchroniser, per-channel glitch filter, quadrature
//   step decoder with illegal-transition detection and a saturating error counter.
//   One instance per player; its outputs feed the paddle movement logic.
// PARAMETERS
//   FILTER_CYCLES  4  consecutive mismatching clocks before a filtered level updates (>=1)
//   DIR_INVERT     0  1 = swap the step_up and step_dn outputs
// PORTS
//   clk        in   1  system clock (pixel clock domain)
//   reset      in   1  asynchronous, active-high reset
//   enc_a      in   1  raw encoder channel A (asynchronous to clk)
//   enc_b      in   1  raw encoder channel B (asynchronous to clk)
//   clear_err  in   1  synchronous clear of err_count
//   a_clean    out  1  filtered channel A level
//   b_clean    out  1  filtered channel B level
//   step_up    out  1  one-clock pulse, one forward quadrature step
//   step_dn    out  1  one-clock pulse, one reverse quadrature step
//   illegal    out  1  one-clock pulse, both filtered bits changed on the same clock
//   err_count  out  8  saturating count of illegal events
// BEHAVIOUR
//   Reset: all flops 0. a_clean=b_clean=0, step_up=step_dn=illegal=0, err_count=0, FSM=INIT.
//     Reset is asynchronous; de-assertion mid-rotation restarts INIT and drops in-flight steps.
//   Sync: per channel, s1<=raw, s2<=s1. Only s2 is used downstream.
//   Filter: per channel, counter of width $clog2(FILTER_CYCLES+1).
//     s2==clean: counter<=0.
//     s2!=clean and counter==FILTER_CYCLES-1: clean<=s2, counter<=0.
//     Otherwise: counter<=counter+1.
//     A pulse shorter than FILTER_CYCLES clocks at s2 never reaches clean.
//   Latency: raw level set before edge 0 gives s2 after edge 1 and clean after edge
//     1+FILTER_CYCLES. A step/illegal pulse is high in the cycle after edge 2+FILTER_CYCLES.
//   FSM states:
//     INIT: settle counter runs FILTER_CYCLES+3 clocks; prev<=clean every clock; no pulses.
//       Moves to TRACK when the settle counter expires.
//     TRACK: prev<={a_clean,b_clean} every clock. Decode prev->cur:
//       Forward (up) sequence: 00->01->11->10->00.
//       Reverse (dn): the opposite direction.
//       No change: nothing.
//       Both bits changed (00<->11, 01<->10): illegal=1, no step.
//     TRACK never returns to INIT except on reset.
//   DIR_INVERT=1 exchanges step_up/step_dn only. Illegal behaviour is unchanged.
//   Pulses are registered and last exactly one clock. step_up, step_dn and illegal are
//     mutually exclusive.
//   err_count:
//     clear_err=1: err_count<=0 (clear has priority over a simultaneous illegal).
//     Else if illegal pulse and err_count!=255: err_count<=err_count+1.
//     At 255 it holds and does not wrap.
// TESTING
//   1. Reset, inputs held 11 for 20 clks -> a/b_clean=1 by edge 5, zero pulses, err_count=0.
//   2. FILTER_CYCLES=4, A=1 for 3 clks then 0 -> a_clean stays 0, no step.
//   3. TRACK, drive 00->01->11->10->00 with 10 clks per state -> 4 step_up pulses, each
//      6 clks after its raw edge. Reverse order -> 4 step_dn pulses. DIR_INVERT=1 swaps them.
//   4. Toggle A and B together from 00 to 11 -> 1 illegal pulse, no step, err_count=1.
//      Repeat 300 times -> err_count=255.
//   5. clear_err on the same clock as an illegal pulse -> err_count=0. The next illegal gives 1.
//   6. Assert reset mid-sequence (state 11) -> outputs 0 at once, INIT re-runs, no spurious pulse.

Source files
------------

// File: rtl/quad_input_conditioner.sv
// Rotary-encoder A/B conditioner: two-flop synchroniser, per-channel glitch filter,
// quadrature step decoder with illegal-transition detection and saturating error count.
module quad_input_conditioner #(
  parameter int FILTER_CYCLES = 4,
  parameter bit DIR_INVERT    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       clear_err,
  output logic       a_clean,
  output logic       b_clean,
  output logic       step_up,
  output logic       step_dn,
  output logic       illegal,
  output logic [7:0] err_count
);

  // state    | meaning
  // ST_INIT  | filters settling; prev tracks clean, no pulses
  // ST_TRACK | decode prev->clean into step/illegal pulses
  typedef enum logic {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam int SW = $clog2(FILTER_CYCLES + 3);
  localparam logic [CW-1:0] CNT_LAST    = CW'(FILTER_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(FILTER_CYCLES + 2);

  logic [1:0]    raw, s1, s2, clean, prev;
  logic [CW-1:0] cnt [2];
  logic [SW-1:0] settle, settle_nxt;
  state_t        state, state_nxt;
  logic          fwd, rev, ill_nxt;

  // bit 1 is channel A, bit 0 is channel B throughout
  assign raw     = {enc_a, enc_b};
  assign a_clean = clean[1];
  assign b_clean = clean[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          clean[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle;
    fwd        = 1'b0;
    rev        = 1'b0;
    ill_nxt    = 1'b0;
    case (state)
      ST_INIT: begin
        if (settle == SETTLE_LAST) state_nxt = ST_TRACK;
        else settle_nxt = settle + SW'(1);
      end
      ST_TRACK: begin
        case ({prev, clean})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd     = 1'b1;
          4'b0100, 4'b1101, 4'b1011, 4'b0010: rev     = 1'b1;
          4'b0011, 4'b1100, 4'b0110, 4'b1001: ill_nxt = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      settle    <= '0;
      prev      <= 2'b00;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      illegal   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state   <= state_nxt;
      settle  <= settle_nxt;
      prev    <= clean;
      step_up <= DIR_INVERT ? rev : fwd;
      step_dn <= DIR_INVERT ? fwd : rev;
      illegal <= ill_nxt;
      // clear wins over a simultaneous illegal pulse
      if (clear_err) err_count <= 8'd0;
      else if (illegal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Directed bench for quad_input_conditioner: normal and direction-inverted instances
// share the same encoder stimulus.
module tb_quad_input_conditioner;

  logic       clk = 1'b0;
  logic       reset, enc_a, enc_b, clear_err;
  logic       a_o, b_o, up_o, dn_o, ill_o;
  logic [7:0] err_o;
  logic       ia_o, ib_o, iup_o, idn_o, iill_o;
  logic [7:0] ierr_o;

  int checks = 0, failures = 0;
  int cnt_up, cnt_dn, cnt_ill, inv_up, inv_dn, inv_ill, multi;
  int lat, found;

  always #5 clk = ~clk;

  quad_input_conditioner #(.FILTER_CYCLES(4), .DIR_INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear_err(clear_err),
    .a_clean(a_o), .b_clean(b_o), .step_up(up_o), .step_dn(dn_o),
    .illegal(ill_o), .err_count(err_o)
  );

  quad_input_conditioner #(.FILTER_CYCLES(4), .DIR_INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear_err(clear_err),
    .a_clean(ia_o), .b_clean(ib_o), .step_up(iup_o), .step_dn(idn_o),
    .illegal(iill_o), .err_count(ierr_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    cnt_up = 0; cnt_dn = 0; cnt_ill = 0;
    inv_up = 0; inv_dn = 0; inv_ill = 0; multi = 0;
  endtask

  // advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (up_o)   cnt_up++;
    if (dn_o)   cnt_dn++;
    if (ill_o)  cnt_ill++;
    if (iup_o)  inv_up++;
    if (idn_o)  inv_dn++;
    if (iill_o) inv_ill++;
    if ((int'(up_o) + int'(dn_o) + int'(ill_o)) > 1) multi++;
  endtask

  // drive a new A/B level, hold n clocks; lat = ticks until first pulse (0 if none)
  task automatic move(input logic [1:0] ab, input int n, output int first);
    enc_a = ab[1];
    enc_b = ab[0];
    first = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (first == 0 && (up_o || dn_o || ill_o)) first = k;
    end
  endtask

  initial begin
    reset = 1'b1; enc_a = 1'b1; enc_b = 1'b1; clear_err = 1'b0;
    clr_counts();
    tick(); tick();
    chk("rst_a_clean", int'(a_o), 0);
    chk("rst_b_clean", int'(b_o), 0);
    chk("rst_pulses", int'(up_o) + int'(dn_o) + int'(ill_o), 0);
    chk("rst_err", int'(err_o), 0);

    // inputs held at 11 from reset release; next edge is edge 0
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("settle_a_edge4", int'(a_o), 0);
    tick();
    chk("settle_a_edge5", int'(a_o), 1);
    chk("settle_b_edge5", int'(b_o), 1);
    for (int k = 0; k < 14; k++) tick();
    chk("settle_pulses", cnt_up + cnt_dn + cnt_ill, 0);
    chk("settle_err", int'(err_o), 0);

    // 3-clock glitch on A must not pass a 4-clock filter
    clr_counts();
    found = 0;
    enc_a = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); if (!a_o) found = 1; end
    enc_a = 1'b1;
    for (int k = 0; k < 12; k++) begin tick(); if (!a_o) found = 1; end
    chk("glitch_a_dropped", found, 0);
    chk("glitch_pulses", cnt_up + cnt_dn + cnt_ill, 0);

    // walk to 00 forward, then full forward cycle
    move(2'b10, 20, lat);
    move(2'b00, 20, lat);
    clr_counts();
    move(2'b01, 10, lat);
    chk("fwd_latency", lat, 7);
    move(2'b11, 10, lat);
    move(2'b10, 10, lat);
    move(2'b00, 10, lat);
    chk("fwd_up", cnt_up, 4);
    chk("fwd_dn", cnt_dn, 0);
    chk("fwd_ill", cnt_ill, 0);
    chk("fwd_inv_dn", inv_dn, 4);
    chk("fwd_inv_up", inv_up, 0);

    clr_counts();
    move(2'b10, 10, lat);
    chk("rev_latency", lat, 7);
    move(2'b11, 10, lat);
    move(2'b01, 10, lat);
    move(2'b00, 10, lat);
    chk("rev_dn", cnt_dn, 4);
    chk("rev_up", cnt_up, 0);
    chk("rev_inv_up", inv_up, 4);
    chk("rev_inv_dn", inv_dn, 0);
    chk("rev_inv_ill", inv_ill, 0);

    // both channels together
    clr_counts();
    move(2'b11, 10, lat);
    chk("ill_count", cnt_ill, 1);
    chk("ill_steps", cnt_up + cnt_dn, 0);
    chk("ill_err1", int'(err_o), 1);
    chk("ill_inv_count", inv_ill, 1);
    for (int i = 0; i < 299; i++) move((i % 2 == 0) ? 2'b00 : 2'b11, 10, lat);
    chk("ill_total", cnt_ill, 300);
    chk("ill_sat_err", int'(err_o), 255);
    chk("ill_sat_steps", cnt_up + cnt_dn, 0);

    // plain clear, then clear colliding with an illegal pulse (at 00 now)
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_plain", int'(err_o), 0);
    move(2'b11, 10, lat);
    chk("clr_next_ill", int'(err_o), 1);
    enc_a = 1'b0; enc_b = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick();
      if (ill_o) found = 1;
    end
    chk("clr_ill_seen", found, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_priority", int'(err_o), 0);
    for (int k = 0; k < 10; k++) tick();
    chk("clr_hold", int'(err_o), 0);
    move(2'b11, 10, lat);
    chk("clr_then_ill", int'(err_o), 1);

    // reset mid-rotation while heading into 11
    move(2'b10, 10, lat);
    move(2'b00, 10, lat);
    move(2'b01, 10, lat);
    enc_a = 1'b1; enc_b = 1'b1;
    tick(); tick(); tick();
    #3 reset = 1'b1;
    #1;
    chk("midrst_b_clean", int'(b_o), 0);
    chk("midrst_err", int'(err_o), 0);
    chk("midrst_pulses", int'(up_o) + int'(dn_o) + int'(ill_o), 0);
    tick(); tick();
    reset = 1'b0;
    clr_counts();
    for (int k = 0; k < 30; k++) tick();
    chk("midrst_no_pulse", cnt_up + cnt_dn + cnt_ill, 0);
    chk("midrst_a_clean", int'(a_o), 1);
    chk("midrst_b_clean2", int'(b_o), 1);
    move(2'b10, 10, lat);
    chk("midrst_track_up", cnt_up, 1);
    chk("midrst_track_ill", cnt_ill, 0);
    chk("excl_pulses", multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
